// File: rtl/arb4x32_rr_if.sv
// Bus bundle between four requesters, the arb4x32_rr arbiter and its consumer.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface arb4x32_rr_if #(
  parameter int W  = 32,
  parameter int CW = 8
);
  logic [3:0]    req;
  logic [W-1:0]  a0;
  logic [W-1:0]  a1;
  logic [W-1:0]  a2;
  logic [W-1:0]  a3;
  logic [3:0]    ack;
  logic [W-1:0]  y;
  logic          y_valid;
  logic          y_ready;
  logic [1:0]    s;
  logic [3:0]    gnt;
  logic [CW-1:0] count;
`ifdef ARB_LOCK_EN
  logic [3:0]    lock;
`endif

  modport slave (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req, a0, a1, a2, a3, y_ready,
    output ack, y, y_valid, s, gnt, count
  );

  modport master (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req, a0, a1, a2, a3, y_ready,
    input  ack, y, y_valid, s, gnt, count
  );
endinterface

// File: rtl/arb4x32_rr.sv
// Round-robin arbiter sharing one registered W-bit output between four requesters.
// Optional owner lock (burst hold) is compiled in with ARB_LOCK_EN.
//
// state | meaning
// EMPTY | y holds no unconsumed word (y_valid=0)
// FULL  | y holds a word waiting for y_ready (y_valid=1)
module arb4x32_rr #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input logic         clk,
  input logic         clrn,
  arb4x32_rr_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q;
  logic [W-1:0]  y_q;
  logic [1:0]    s_q;
  logic [3:0]    gnt_q;
  logic [1:0]    last_q;
  logic [CW-1:0] count_q;

  logic [1:0]    win_d;
  logic [1:0]    idx;
  logic          hit;
  logic          lock_hold;
  logic          load;
  logic          consume;
  logic [W-1:0]  y_d;

  // Scan starts just after the previous winner so everyone gets a turn.
  always_comb begin
    win_d     = last_q;
    idx       = last_q;
    hit       = 1'b0;
    lock_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!hit && bus.req[idx]) begin
        win_d = idx;
        hit   = 1'b1;
      end
    end
`ifdef ARB_LOCK_EN
    lock_hold = |(gnt_q & bus.lock & bus.req);
    if (lock_hold) begin
      win_d = s_q;
    end
`endif
  end

  assign load    = clrn && (|bus.req) && ((state_q == EMPTY) || bus.y_ready);
  assign consume = (state_q == FULL) && bus.y_ready;

  always_comb begin
    y_d = bus.a0;
    unique case (win_d)
      2'd0: y_d = bus.a0;
      2'd1: y_d = bus.a1;
      2'd2: y_d = bus.a2;
      2'd3: y_d = bus.a3;
      default: y_d = bus.a0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= EMPTY;
      y_q     <= '0;
      s_q     <= 2'd0;
      gnt_q   <= 4'b0000;
      last_q  <= 2'd3;
      count_q <= '0;
    end else begin
      if (consume) begin
        count_q <= count_q + 1'b1;
      end
      if (load) begin
        state_q <= FULL;
        y_q     <= y_d;
        s_q     <= win_d;
        gnt_q   <= 4'b0001 << win_d;
        if (!lock_hold) begin
          last_q <= win_d;
        end
      end else if (consume) begin
        // y and s keep the last word; only ownership is cleared.
        state_q <= EMPTY;
        gnt_q   <= 4'b0000;
      end
    end
  end

  assign bus.ack     = load ? (4'b0001 << win_d) : 4'b0000;
  assign bus.y       = y_q;
  assign bus.y_valid = (state_q == FULL);
  assign bus.s       = s_q;
  assign bus.gnt     = gnt_q;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_arb4x32_rr.sv
// Directed bench for arb4x32_rr: main instance with CW=8 plus a CW=2 instance for count wrap.
module tb_arb4x32_rr;

  logic clk;
  logic clrn;
  int   n_vec;
  int   n_err;

  arb4x32_rr_if #(.W(32), .CW(8)) bus ();
  arb4x32_rr_if #(.W(32), .CW(2)) bus2 ();

  arb4x32_rr #(.W(32), .CW(8)) u_dut (.clk(clk), .clrn(clrn), .bus(bus));
  arb4x32_rr #(.W(32), .CW(2)) u_dut2 (.clk(clk), .clrn(clrn), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = 4'b0000; bus.y_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    bus2.req = 4'b0000; bus2.y_ready = 1'b0;
    bus2.a0 = '0; bus2.a1 = '0; bus2.a2 = '0; bus2.a3 = '0;
`ifdef ARB_LOCK_EN
    bus.lock = 4'b0000; bus2.lock = 4'b0000;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    clear_inputs();
    bus.req = 4'b1111;
    #3;
    n_vec++; if (bus.y !== 32'h0) begin n_err++; $display("FAIL rst_y got %h exp 0", bus.y); end
    n_vec++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", bus.y_valid); end
    n_vec++; if (bus.s !== 2'b00) begin n_err++; $display("FAIL rst_s got %b exp 00", bus.s); end
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt got %b exp 0000", bus.gnt); end
    n_vec++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack got %b exp 0000", bus.ack); end
    bus.req = 4'b0001; bus.a0 = 32'hF000_0000; bus.y_ready = 1'b1;
    clrn = 1'b1;
    #1;
    n_vec++; if (bus.ack !== 4'b0001) begin n_err++; $display("FAIL t1_ack got %b exp 0001", bus.ack); end
    tick();
    bus.req = 4'b0000;
    n_vec++; if (bus.y !== 32'hF000_0000) begin n_err++; $display("FAIL t1_y got %h exp F0000000", bus.y); end
    n_vec++; if (bus.s !== 2'b00) begin n_err++; $display("FAIL t1_s got %b exp 00", bus.s); end
    n_vec++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL t1_gnt got %b exp 0001", bus.gnt); end
    n_vec++; if (bus.y_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got %b exp 1", bus.y_valid); end
    tick();
    n_vec++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL t1_empty got %b exp 0", bus.y_valid); end
    n_vec++; if (bus.count !== 8'd1) begin n_err++; $display("FAIL t1_count got %0d exp 1", bus.count); end
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL t1_gnt_clr got %b exp 0000", bus.gnt); end
    n_vec++; if (bus.y !== 32'hF000_0000) begin n_err++; $display("FAIL t1_y_hold got %h exp F0000000", bus.y); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_ack;
    do_reset();
    bus.req = 4'b1111; bus.y_ready = 1'b1;
    bus.a0 = 32'd1; bus.a1 = 32'd2; bus.a2 = 32'd3; bus.a3 = 32'd4;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_ack = 4'b0001 << (i % 4);
      n_vec++; if (bus.ack !== exp_ack) begin n_err++; $display("FAIL rot_ack[%0d] got %b exp %b", i, bus.ack, exp_ack); end
      tick();
      n_vec++; if (bus.s !== 2'(i % 4)) begin n_err++; $display("FAIL rot_s[%0d] got %b exp %0d", i, bus.s, i % 4); end
      n_vec++; if (bus.y !== 32'((i % 4) + 1)) begin n_err++; $display("FAIL rot_y[%0d] got %h exp %0d", i, bus.y, (i % 4) + 1); end
      n_vec++; if (bus.count !== 8'(i)) begin n_err++; $display("FAIL rot_count[%0d] got %0d exp %0d", i, bus.count, i); end
    end
    bus.req = 4'b0000;
    tick();
    n_vec++; if (bus.count !== 8'd8) begin n_err++; $display("FAIL rot_count_end got %0d exp 8", bus.count); end
    n_vec++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL rot_empty got %b exp 0", bus.y_valid); end
  endtask

  task automatic test_backpressure();
    bus.req = 4'b1000; bus.a3 = 32'h0000_00BA; bus.y_ready = 1'b0;
    tick();
    bus.req = 4'b0101; bus.a0 = 32'h0000_00A0; bus.a2 = 32'h0000_00A2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL bp_ack[%0d] got %b exp 0000", i, bus.ack); end
      tick();
      n_vec++; if (bus.y !== 32'h0000_00BA) begin n_err++; $display("FAIL bp_y[%0d] got %h exp 000000BA", i, bus.y); end
      n_vec++; if (bus.s !== 2'b11) begin n_err++; $display("FAIL bp_s[%0d] got %b exp 11", i, bus.s); end
      n_vec++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL bp_gnt[%0d] got %b exp 1000", i, bus.gnt); end
      n_vec++; if (bus.y_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.y_valid); end
    end
    bus.y_ready = 1'b1;
    #1;
    n_vec++; if (bus.ack !== 4'b0001) begin n_err++; $display("FAIL bp_release_ack got %b exp 0001", bus.ack); end
    tick();
    bus.req = 4'b0100;
    n_vec++; if (bus.y !== 32'h0000_00A0) begin n_err++; $display("FAIL bp_y_a0 got %h exp 000000A0", bus.y); end
    n_vec++; if (bus.count !== 8'd9) begin n_err++; $display("FAIL bp_count got %0d exp 9", bus.count); end
    #1;
    n_vec++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL bp_ack2 got %b exp 0100", bus.ack); end
    tick();
    bus.req = 4'b0000;
    n_vec++; if (bus.s !== 2'b10) begin n_err++; $display("FAIL bp_s2 got %b exp 10", bus.s); end
    tick();
    n_vec++; if (bus.count !== 8'd11) begin n_err++; $display("FAIL bp_count_end got %0d exp 11", bus.count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0001; bus.a0 = 32'h1234_5678; bus.y_ready = 1'b1;
    repeat (6) tick();
    n_vec++; if (bus.count !== 8'd5) begin n_err++; $display("FAIL ar_pre_count got %0d exp 5", bus.count); end
    n_vec++; if (bus.y_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got %b exp 1", bus.y_valid); end
    bus.req = 4'b0000; bus.y_ready = 1'b0;
    #1;
    clrn = 1'b0;
    #1;
    n_vec++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b exp 0", bus.y_valid); end
    n_vec++; if (bus.y !== 32'h0) begin n_err++; $display("FAIL ar_y got %h exp 0", bus.y); end
    n_vec++; if (bus.gnt !== 4'b0000 || bus.s !== 2'b00) begin n_err++; $display("FAIL ar_gnt_s got %b/%b exp 0000/00", bus.gnt, bus.s); end
    n_vec++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL ar_count got %0d exp 0", bus.count); end
    bus.req = 4'b1000; bus.a3 = 32'h0000_0333;
    #1;
    clrn = 1'b1;
    #1;
    n_vec++; if (bus.ack !== 4'b1000) begin n_err++; $display("FAIL ar_ack got %b exp 1000", bus.ack); end
    tick();
    bus.req = 4'b0000;
    n_vec++; if (bus.s !== 2'b11) begin n_err++; $display("FAIL ar_s got %b exp 11", bus.s); end
    n_vec++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL ar_gnt got %b exp 1000", bus.gnt); end
    n_vec++; if (bus.y !== 32'h0000_0333) begin n_err++; $display("FAIL ar_y_a3 got %h exp 00000333", bus.y); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [6];
    exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    bus2.req = 4'b0001; bus2.a0 = 32'h5; bus2.y_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 4) bus2.req = 4'b0000;
      n_vec++; if (bus2.count !== exp_cnt[k]) begin n_err++; $display("FAIL wrap_count[%0d] got %0d exp %0d", k, bus2.count, exp_cnt[k]); end
    end
    n_vec++; if (bus2.y_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %b exp 0", bus2.y_valid); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.req = 4'b0010; bus.lock = 4'b0010; bus.y_ready = 1'b1;
    bus.a0 = 32'hA0; bus.a1 = 32'hA1; bus.a2 = 32'hA2;
    tick();
    n_vec++; if (bus.s !== 2'b01) begin n_err++; $display("FAIL lock_owner got %b exp 01", bus.s); end
    bus.req = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (bus.s !== 2'b01) begin n_err++; $display("FAIL lock_s[%0d] got %b exp 01", i, bus.s); end
    end
    bus.lock = 4'b0000;
    tick();
    n_vec++; if (bus.s !== 2'b10) begin n_err++; $display("FAIL lock_rel_s got %b exp 10", bus.s); end
    tick();
    n_vec++; if (bus.s !== 2'b00) begin n_err++; $display("FAIL lock_next_s got %b exp 00", bus.s); end
    bus.req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_async_reset();
    test_count_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
